// File: rtl/index_release_mask.sv
// Collects released 6-bit indices into a 64-bit pending mask and offers it on a count threshold or an age timeout.
// Optional macro RELEASE_DUP_CHECK_EN builds duplicate-release detection on dup_err.
module index_release_mask #(
  parameter int THRESH  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rel0_en,
  input  logic [5:0]  rel0_idx,
  input  logic        rel1_en,
  input  logic [5:0]  rel1_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_mask,
  output logic [6:0]  out_cnt,
  output logic        hasany,
  output logic        dup_err
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    OFFER   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pend;
  logic [63:0] w_new_bits;
  logic [63:0] w_surv;
  logic [63:0] w_pend_next;
  logic [6:0]  r_cnt;
  logic [6:0]  w_cnt_next;
  logic [3:0]  r_age;
  logic [3:0]  w_age_next;
  logic        w_xfer;
  logic        w_same;
  logic        w_new0;
  logic        w_new1;
  logic        w_offer;

  // The count is tracked incrementally: only bits absent from the surviving mask add to it.
  always_comb begin
    w_new_bits = '0;
    if (rel0_en) w_new_bits[rel0_idx] = 1'b1;
    if (rel1_en) w_new_bits[rel1_idx] = 1'b1;
    w_xfer      = (r_state == OFFER) && out_ready;
    w_surv      = w_xfer ? 64'd0 : r_pend;
    w_same      = rel0_en && rel1_en && (rel0_idx == rel1_idx);
    w_new0      = rel0_en && !w_surv[rel0_idx];
    w_new1      = rel1_en && !w_surv[rel1_idx] && !w_same;
    w_cnt_next  = (w_xfer ? 7'd0 : r_cnt) + {6'd0, w_new0} + {6'd0, w_new1};
    w_pend_next = w_surv | w_new_bits;
  end

  always_comb begin
    w_age_next = 4'd0;
    if (w_cnt_next != 7'd0) begin
      if (w_xfer || (r_cnt == 7'd0))
        w_age_next = 4'd1;
      else if (r_age == 4'(TIMEOUT))
        w_age_next = r_age;
      else
        w_age_next = r_age + 4'd1;
    end
  end

  // Next state is chosen from the next count and age, so OFFER always matches the valid rule.
  always_comb begin
    w_state_next = r_state;
    w_offer = (int'(w_cnt_next) >= THRESH) ||
              ((w_cnt_next != 7'd0) && (w_age_next == 4'(TIMEOUT)));
    case (r_state)
      EMPTY, COLLECT, OFFER: begin
        if (w_offer)
          w_state_next = OFFER;
        else if (w_cnt_next != 7'd0)
          w_state_next = COLLECT;
        else
          w_state_next = EMPTY;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_age   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_cnt   <= w_cnt_next;
      r_age   <= w_age_next;
    end
  end

`ifdef RELEASE_DUP_CHECK_EN
  logic r_dup;

  // Re-releasing a bit that is being drained in this cycle is legitimate, not a duplicate.
  always_ff @(posedge clk) begin
    if (rst)
      r_dup <= 1'b0;
    else
      r_dup <= w_same ||
               (!w_xfer && ((rel0_en && r_pend[rel0_idx]) || (rel1_en && r_pend[rel1_idx])));
  end

  assign dup_err = r_dup;
`else
  assign dup_err = 1'b0;
`endif

  assign out_valid = (r_state == OFFER);
  assign out_mask  = r_pend;
  assign out_cnt   = r_cnt;
  assign hasany    = (r_cnt != 7'd0);

endmodule

// File: tb/tb_index_release_mask.sv
// Self-checking bench for index_release_mask: directed scenarios then randomized traffic against a set-based model.
module tb_index_release_mask;

  localparam int THRESH  = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rel0_en = 1'b0;
  logic [5:0]  rel0_idx = '0;
  logic        rel1_en = 1'b0;
  logic [5:0]  rel1_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_mask;
  logic [6:0]  out_cnt;
  logic        hasany;
  logic        dup_err;

  int passCount = 0;
  int totalCount = 0;

  bit [63:0] mPend = '0;
  int        mAge = 0;
  bit        mDup = 1'b0;

`ifdef RELEASE_DUP_CHECK_EN
  localparam bit DUP_ON = 1'b1;
`else
  localparam bit DUP_ON = 1'b0;
`endif

  index_release_mask #(.THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rel0_en(rel0_en), .rel0_idx(rel0_idx),
    .rel1_en(rel1_en), .rel1_idx(rel1_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_cnt(out_cnt),
    .hasany(hasany), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  // The offer rule: enough distinct indices, or anything pending that has waited long enough.
  function automatic bit modelValid(input bit [63:0] pend, input int age);
    int n;
    n = $countones(pend);
    return (n >= THRESH) || (n != 0 && age == TIMEOUT);
  endfunction

  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    totalCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".mask"},  out_mask, mPend);
    check1({tag, ".cnt"},   64'(out_cnt), 64'($countones(mPend)));
    check1({tag, ".valid"}, 64'(out_valid), 64'(modelValid(mPend, mAge)));
    check1({tag, ".any"},   64'(hasany), 64'(mPend != 0));
    check1({tag, ".dup"},   64'(dup_err), 64'(mDup & DUP_ON));
  endtask

  // Update the model with the pre-edge state, clock once, then compare.
  task automatic applyStimulus(input bit r, input bit e0, input bit [5:0] i0,
                               input bit e1, input bit [5:0] i1, input bit rdy,
                               input string tag);
    bit [63:0] newBits;
    bit        xfer;
    bit        wasEmpty;
    rst = r; rel0_en = e0; rel0_idx = i0; rel1_en = e1; rel1_idx = i1; out_ready = rdy;
    if (r) begin
      mPend = '0; mAge = 0; mDup = 1'b0;
    end else begin
      newBits = '0;
      if (e0) newBits[i0] = 1'b1;
      if (e1) newBits[i1] = 1'b1;
      xfer = modelValid(mPend, mAge) && rdy;
      mDup = (e0 && e1 && i0 == i1) ||
             (!xfer && ((e0 && mPend[i0]) || (e1 && mPend[i1])));
      if (xfer) begin
        mPend = newBits;
        mAge = (newBits != 0) ? 1 : 0;
      end else begin
        wasEmpty = (mPend == 0);
        mPend = mPend | newBits;
        if (mPend == 0) mAge = 0;
        else if (wasEmpty) mAge = 1;
        else if (mAge < TIMEOUT) mAge = mAge + 1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int n;
    bit r, e0, e1, rdy;
    bit [5:0] i0, i1;

    // Reset state
    applyStimulus(1, 1, 6'd12, 1, 6'd40, 1, "reset0");
    applyStimulus(1, 0, 6'd0, 0, 6'd0, 0, "reset1");
    check1("reset.cnt", 64'(out_cnt), 64'd0);

    // Threshold reached on the fourth distinct index
    applyStimulus(0, 1, 6'd0, 0, 6'd0, 0, "thr0");
    applyStimulus(0, 1, 6'd63, 0, 6'd0, 0, "thr1");
    applyStimulus(0, 1, 6'd17, 0, 6'd0, 0, "thr2");
    check1("thr.notyet", 64'(out_valid), 64'd0);
    applyStimulus(0, 1, 6'd5, 0, 6'd0, 0, "thr3");
    check1("thr.valid", 64'(out_valid), 64'd1);
    check1("thr.mask", out_mask, 64'h8000_0000_0002_0021);
    check1("thr.cnt", 64'(out_cnt), 64'd4);

    // Release colliding with a transfer lands in the next mask
    applyStimulus(0, 1, 6'd3, 0, 6'd0, 1, "coll");
    check1("coll.mask", out_mask, 64'h8);
    check1("coll.cnt", 64'(out_cnt), 64'd1);

    // Timeout on a single pending index
    applyStimulus(1, 0, 6'd0, 0, 6'd0, 0, "tmo.rst");
    applyStimulus(0, 1, 6'd9, 0, 6'd0, 1, "tmo.rel");
    n = 0;
    while (!out_valid && n < 20) begin
      applyStimulus(0, 0, 6'd0, 0, 6'd0, 1, "tmo.wait");
      n++;
    end
    check1("tmo.cycles", 64'(n), 64'd14);
    applyStimulus(0, 0, 6'd0, 0, 6'd0, 1, "tmo.xfer");
    check1("tmo.cnt", 64'(out_cnt), 64'd0);
    check1("tmo.valid", 64'(out_valid), 64'd0);

    // Same index on both slots counts once
    applyStimulus(0, 1, 6'd42, 1, 6'd42, 0, "same");
    check1("same.cnt", 64'(out_cnt), 64'd1);
    check1("same.dup", 64'(dup_err), 64'(DUP_ON));
    applyStimulus(0, 0, 6'd0, 0, 6'd0, 0, "same.idle");
    check1("same.dupclr", 64'(dup_err), 64'd0);

    // Duplicate versus drain of bit 7
    applyStimulus(1, 0, 6'd0, 0, 6'd0, 0, "dd.rst");
    applyStimulus(0, 1, 6'd7, 0, 6'd0, 0, "dd.rel");
    applyStimulus(0, 1, 6'd7, 0, 6'd0, 0, "dd.dup");
    check1("dd.dupflag", 64'(dup_err), 64'(DUP_ON));
    check1("dd.cnt", 64'(out_cnt), 64'd1);
    applyStimulus(0, 1, 6'd1, 1, 6'd2, 0, "dd.fill0");
    applyStimulus(0, 1, 6'd3, 0, 6'd0, 0, "dd.fill1");
    applyStimulus(0, 1, 6'd7, 0, 6'd0, 1, "dd.drain");
    check1("dd.nodup", 64'(dup_err), 64'd0);
    check1("dd.mask", out_mask, 64'h80);

    // Reset in OFFER discards everything, including the concurrent release
    applyStimulus(1, 0, 6'd0, 0, 6'd0, 0, "ro.rst");
    applyStimulus(0, 1, 6'd10, 1, 6'd11, 0, "ro.f0");
    applyStimulus(0, 1, 6'd12, 1, 6'd13, 0, "ro.f1");
    applyStimulus(0, 1, 6'd14, 0, 6'd0, 0, "ro.f2");
    check1("ro.cnt5", 64'(out_cnt), 64'd5);
    applyStimulus(1, 1, 6'd1, 0, 6'd0, 1, "ro.hit");
    check1("ro.mask", out_mask, 64'd0);
    check1("ro.valid", 64'(out_valid), 64'd0);
    check1("ro.any", 64'(hasany), 64'd0);

    // Randomized traffic; narrow index range provokes duplicates
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 49) == 0);
      e0  = $urandom_range(0, 2) != 0;
      e1  = $urandom_range(0, 2) == 0;
      i0  = (k < 200) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      i1  = (k < 200) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      rdy = $urandom_range(0, 3) == 0;
      applyStimulus(r, e0, i0, e1, i1, rdy, "rand");
    end

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/index_release_mask.md
INDEX_RELEASE_MASK -- requirements
Module: index_release_mask

Interface
REQ-001 Parameter THRESH, default 4, is the pending-count threshold that forces out_valid.
REQ-002 Parameter TIMEOUT, default 15, range 1..15, is the age in cycles after which any non-empty pending mask forces out_valid.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, is the reset; it is synchronous and active-high.
REQ-005 Port rel0_en, input, 1, is the release strobe for slot 0.
REQ-006 Port rel0_idx, input, 6, is the released index for slot 0.
REQ-007 Port rel1_en, input, 1, is the release strobe for slot 1.
REQ-008 Port rel1_idx, input, 6, is the released index for slot 1.
REQ-009 Port out_valid, output, 1, indicates that out_mask is offered to the allocator.
REQ-010 Port out_ready, input, 1, is the allocator's acceptance of out_mask.
REQ-011 Port out_mask, output, 64, is the pending one-hot union of released indices.
REQ-012 Port out_cnt, output, 7, is the population count of out_mask, range 0..64.
REQ-013 Port hasany, output, 1, is |out_mask.
REQ-014 Port dup_err, output, 1, is the duplicate-release pulse (see Configuration).

Function
REQ-015 Each enabled release slot SHALL decode its 6-bit index to a 64-bit one-hot vector; decoded vectors of both slots SHALL be OR-ed into new_bits.
REQ-016 Releases SHALL always be accepted; there is no input backpressure.
REQ-017 The pending register pend SHALL update as follows: with no transfer, pend <= pend | new_bits; with a transfer (out_valid && out_ready), pend <= new_bits.
REQ-018 out_mask SHALL equal pend, and out_cnt SHALL equal the registered popcount of pend, maintained incrementally with no combinational 64-bit popcount on the output path.
REQ-019 Only indices not already set in the surviving pend SHALL increment out_cnt; when both slots carry the same index in one cycle, that index SHALL count once.
REQ-020 A 4-bit age counter SHALL be 0 when pend is empty or on a transfer cycle, SHALL become 1 when pend becomes non-empty, SHALL increment each cycle while pend is non-empty, and SHALL saturate at TIMEOUT.
REQ-021 out_valid SHALL equal (out_cnt >= THRESH) || (out_cnt != 0 && age == TIMEOUT), derived from registers only.
REQ-022 out_valid SHALL be 0 whenever pend is empty.
REQ-023 Once asserted, out_valid SHALL remain asserted and out_mask SHALL only gain bits until a transfer occurs.
REQ-024 The latency from a release strobe to the corresponding bit appearing in out_mask SHALL be exactly one cycle.
REQ-025 A release arriving in a transfer cycle SHALL appear only in the next mask, never in the transferred one and never lost.
REQ-026 The state machine SHALL have three states: EMPTY (pend == 0), COLLECT (pend != 0, out_valid == 0) and OFFER (out_valid == 1). Transitions: EMPTY->COLLECT on any release; COLLECT->OFFER on the threshold or timeout condition; OFFER->EMPTY on a transfer with no release; OFFER->COLLECT or OFFER->OFFER on a transfer with releases, according to the new count.

Reset
REQ-027 While rst is asserted at a clock edge, pend, out_cnt, age and dup_err SHALL clear to 0 and out_valid SHALL be 0 the following cycle.
REQ-028 Releases and out_ready presented during a reset cycle SHALL be ignored.
REQ-029 Reset asserted mid-OFFER SHALL discard the pending mask without a transfer.

Configuration
REQ-030 With macro RELEASE_DUP_CHECK_EN defined, dup_err SHALL pulse high for one cycle, one cycle after any of the following: an enabled slot releases an index already set in pend on a non-transfer cycle, or both slots release the same index in one cycle.
REQ-031 With RELEASE_DUP_CHECK_EN defined, a release of an index set in pend on a transfer cycle SHALL NOT flag dup_err.
REQ-032 Without RELEASE_DUP_CHECK_EN, dup_err SHALL be tied to 0 and no comparison logic SHALL be built.
REQ-033 All other behaviour SHALL be identical with and without RELEASE_DUP_CHECK_EN.

Verification
REQ-034 Threshold: THRESH=4; release indices 0, 63, 17, 5 on single cycles -> out_valid rises the cycle after the fourth release, out_mask = 0x8000_0000_0002_0021, out_cnt = 4.
REQ-035 Timeout: release index 9 only, out_ready = 1 -> out_valid rises on the 15th cycle after out_mask bit 9 sets; the transfer then returns to EMPTY with out_cnt = 0.
REQ-036 Transfer collision: in OFFER, assert out_ready together with rel0 idx 3 -> the transferred mask excludes bit 3; next-cycle out_mask = 0x8 and out_cnt = 1.
REQ-037 Same-index dual release: rel0 = rel1 = 42 -> out_cnt increments by 1; dup_err = 1 one cycle later only when RELEASE_DUP_CHECK_EN is defined.
REQ-038 Duplicate versus drain: with RELEASE_DUP_CHECK_EN defined and bit 7 pending, release 7 without a transfer -> dup_err pulse and out_cnt unchanged; release 7 on a transfer cycle -> no dup_err and out_mask = 0x80.
REQ-039 Reset mid-OFFER: in OFFER with out_cnt = 5, assert rst for 1 cycle together with rel0 idx 1 -> out_mask = 0, out_valid = 0, out_cnt = 0, hasany = 0.
